// File: rtl/one_four_demux_pkg.sv
// Shared constants and helpers for the one-to-four demultiplexer.
package one_four_demux_pkg;

  localparam int unsigned NCH       = 4;  // output channels (fixed)
  localparam int unsigned SEL_W     = 2;  // channel index width
  localparam int unsigned DEF_WIDTH = 8;  // default data word width

  // Next round-robin pointer; wraps naturally at NCH because SEL_W = log2(NCH).
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
    return ptr + SEL_W'(1);
  endfunction

endpackage : one_four_demux_pkg

// File: rtl/demux_slot.sv
// One-entry holding slot: valid bit plus data register.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load_i      - capture data_i and set valid at next edge
//   drain_i     - consumer takes the held word; clears valid unless reloaded
//   data_i      - word to capture
//   valid_o     - slot holds a word
//   data_o      - held word (retains last loaded value when empty)
module demux_slot
  import one_four_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // A load wins over a drain, so a same-cycle drain+refill keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : demux_slot

// File: rtl/one_four_demux.sv
// One-to-four demultiplexer with per-channel one-entry slots.
// Target is either in_sel or an internal round-robin pointer (in_auto).
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_data     - upstream word
//   in_sel, in_auto      - explicit target / round-robin mode select
//   in_ready             - word accepted this cycle when in_valid is high
//   out_valid/out_data   - per-channel held word, channel k at [k*WIDTH +: WIDTH]
//   out_ready            - per-channel downstream accept
//   rr_ptr               - current round-robin pointer
//   busy                 - any channel holds a word
module one_four_demux
  import one_four_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_auto,
  output logic                 in_ready,
  output logic [NCH-1:0]       out_valid,
  output logic [NCH*WIDTH-1:0] out_data,
  input  logic [NCH-1:0]       out_ready,
  output logic [SEL_W-1:0]     rr_ptr,
  output logic                 busy
);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] tgt;
  logic             accept;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   drain;

  // Target channel and readiness look only at the targeted slot.
  assign tgt      = in_auto ? rr_ptr_q : in_sel;
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign accept   = in_valid && in_ready;

  // Per-channel load strobes and drain handshakes.
  always_comb begin
    load = '0;
    for (int k = 0; k < NCH; k++) begin
      if (accept && (tgt == SEL_W'(k))) load[k] = 1'b1;
    end
  end

  assign drain = out_valid & out_ready;

  // Pointer advances only on an accepted word in round-robin mode.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && in_auto) rr_ptr_d = rr_next(rr_ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[g]),
      .drain_i (drain[g]),
      .data_i  (in_data),
      .valid_o (out_valid[g]),
      .data_o  (out_data[g*WIDTH +: WIDTH])
    );
  end

  assign rr_ptr = rr_ptr_q;
  assign busy   = |out_valid;

endmodule : one_four_demux

// File: tb/tb_one_four_demux.sv
// Scoreboard bench for one_four_demux: per-channel queues of expected words,
// stimulus pushes on predicted accepts, negedge monitor pops on drains.
module tb_one_four_demux;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_auto;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic        busy;

  one_four_demux #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_auto   (in_auto),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: words accepted but not yet drained, last loaded word, pointer.
  logic [7:0] exp_q [4][$];
  logic [7:0] last_w [4];
  logic [1:0] m_rr;
  logic [7:0] mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last_w[k] = 8'h00;
    end
    m_rr = 2'd0;
  endtask

  // One clock: drive at posedge+1, check state and readiness at posedge+2,
  // and record the accept the model predicts.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic a, input logic [3:0] r);
    logic [3:0] exp_v;
    logic [1:0] t;
    logic       exp_rdy;
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; in_sel = s; in_auto = a; out_ready = r;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_v[k] = (exp_q[k].size() != 0);
      chk("hold_data", 32'(out_data[k*8 +: 8]), 32'(last_w[k]));
    end
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("busy", 32'(busy), 32'(exp_v != 4'b0000));
    chk("rr_ptr", 32'(rr_ptr), 32'(m_rr));
    t       = a ? m_rr : s;
    exp_rdy = (exp_q[t].size() == 0) || r[t];
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (v && exp_rdy) begin
      exp_q[t].push_back(d);
      last_w[t] = d;
      if (a) m_rr = m_rr + 2'd1;
    end
  endtask

  // Monitor: every drained word must be the oldest one expected on that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("unexpected_word", 32'(1), 32'(0));
          end else begin
            mon_w = exp_q[k].pop_front();
            chk("drain_data", 32'(out_data[k*8 +: 8]), 32'(mon_w));
          end
        end
      end
    end
  end

  task automatic async_reset();
    @(posedge clk);
    #3;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_rr_ptr", 32'(rr_ptr), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_data", out_data, 32'(0));
    model_reset();
    @(posedge clk);
    #2;
    chk("rst_no_accept", 32'(out_valid), 32'(0));
    @(negedge clk);
    #2;
    rst_n    = 1'b0 | 1'b1;
    in_valid = 1'b0;
  endtask

  logic       mode_auto;
  logic [3:0] rnd_rdy;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd0;
    in_auto = 1'b0; out_ready = 4'b0000;
    model_reset();
    #3;
    chk("init_out_valid", 32'(out_valid), 32'(0));
    chk("init_in_ready", 32'(in_ready), 32'(1));
    chk("init_rr_ptr", 32'(rr_ptr), 32'(0));
    #19;
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Manual route to channel 2, then drained.
    cycle(1'b1, 8'hA5, 2'd2, 1'b0, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    chk("manual_ch2_valid", 32'(out_valid), 32'(4'b0100));
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

    // Round-robin wrap over five words.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 2'd0, 1'b1, 4'b1111);
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 4'b1111);
    chk("rr_wrap_ptr", 32'(rr_ptr), 32'(1));

    // Backpressure on channel 1.
    cycle(1'b1, 8'h33, 2'd1, 1'b0, 4'b1101);
    cycle(1'b1, 8'h44, 2'd1, 1'b0, 4'b1101);
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    cycle(1'b1, 8'h44, 2'd1, 1'b0, 4'b1101);
    cycle(1'b1, 8'h44, 2'd1, 1'b0, 4'b1111);
    cycle(1'b0, 8'h00, 2'd1, 1'b0, 4'b1101);
    chk("bp_ch1_data", 32'(out_data[15:8]), 32'(8'h44));
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

    // Same-cycle drain and refill on channel 3.
    cycle(1'b1, 8'h55, 2'd3, 1'b0, 4'b0000);
    cycle(1'b1, 8'h66, 2'd3, 1'b0, 4'b1000);
    chk("refill_in_ready", 32'(in_ready), 32'(1));
    cycle(1'b0, 8'h00, 2'd3, 1'b0, 4'b0000);
    chk("refill_valid3", 32'(out_valid[3]), 32'(1));
    chk("refill_data3", 32'(out_data[31:24]), 32'(8'h66));
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

    // Auto-mode stall with pointer at 2 and channel 2 full.
    async_reset();
    cycle(1'b1, 8'h20, 2'd0, 1'b1, 4'b1111);
    cycle(1'b1, 8'h21, 2'd0, 1'b1, 4'b1111);
    cycle(1'b1, 8'h22, 2'd2, 1'b0, 4'b1011);
    cycle(1'b1, 8'h77, 2'd0, 1'b1, 4'b1011);
    chk("stall_in_ready", 32'(in_ready), 32'(0));
    cycle(1'b1, 8'h78, 2'd0, 1'b1, 4'b1011);
    chk("stall_rr_ptr", 32'(rr_ptr), 32'(2));

    // Async reset with channels 0 and 1 full.
    cycle(1'b1, 8'h30, 2'd0, 1'b0, 4'b0000);
    cycle(1'b1, 8'h31, 2'd1, 1'b0, 4'b0000);
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    chk("pre_rst_valid01", 32'(out_valid[1:0]), 32'(2'b11));
    async_reset();

    // Randomized traffic with mode switching.
    mode_auto = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) mode_auto = ~mode_auto;
      rnd_rdy = 4'($urandom);
      cycle(($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom), mode_auto, rnd_rdy);
    end

    // Flush and confirm nothing was lost.
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++) chk("flush_empty", 32'(exp_q[k].size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_one_four_demux
